// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC generation, pipelined instruction-memory requests and
// a FIFO of fetched {pc, pc+4, instr} entries presented to decode over valid/ready.
module if_fetch_queue #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              FETCH_DEPTH     = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic            im_req_o,
    output logic [XLEN-1:0] im_addr_o,
    input  logic            im_gnt_i,
    input  logic            im_rvalid_i,
    input  logic [XLEN-1:0] im_rdata_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc_add4_o,
    output logic [XLEN-1:0] id_instr_o,
    output logic            busy_o
);

    localparam int PW = $clog2(FETCH_DEPTH);
    localparam int CW = PW + 1;
    localparam int MW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        FETCH,
        FLUSH
    } state_t;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] p);
        return p + XLEN'(4);
    endfunction

    function automatic logic [MW-1:0] meta_inc(input logic [MW-1:0] p);
        return (p == MW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t          state, state_d;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] fifo_pc    [FETCH_DEPTH];
    logic [XLEN-1:0] fifo_pc4   [FETCH_DEPTH];
    logic [XLEN-1:0] fifo_instr [FETCH_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] meta_pc    [MAX_OUTSTANDING];
    logic [MW-1:0]   meta_wr, meta_rd;
    logic [OW-1:0]   outstanding, outstanding_d;
    logic [OW-1:0]   drop_cnt, drop_cnt_d;
    logic [OW-1:0]   pending;
    logic [CW:0]     occupancy;
    logic            empty, head_vld;
    logic            issue, rsp_accept, push, pop;

    // Responses that will still land in the FIFO reserve a slot, dropped ones do not
    assign pending    = outstanding - drop_cnt;
    assign occupancy  = (CW+1)'(count) + (CW+1)'(pending);
    assign empty      = (count == '0);

    assign im_req_o   = rst && !redirect_i && !halt_i
                        && (outstanding < OW'(MAX_OUTSTANDING))
                        && (occupancy < (CW+1)'(FETCH_DEPTH));
    assign im_addr_o  = pc;
    assign issue      = im_req_o && im_gnt_i;
    // A response with nothing outstanding is stray and must not disturb the counters
    assign rsp_accept = rst && im_rvalid_i && (outstanding != '0);
    assign push       = rsp_accept && !redirect_i && (state == FETCH);

    assign head_vld     = rst && !empty;
    assign id_valid_o   = head_vld && !redirect_i;
    assign pop          = id_valid_o && id_ready_i;
    assign id_pc_o      = head_vld ? fifo_pc[rd_ptr]    : '0;
    assign id_pc_add4_o = head_vld ? fifo_pc4[rd_ptr]   : '0;
    assign id_instr_o   = head_vld ? fifo_instr[rd_ptr] : '0;
    assign busy_o       = rst && ((outstanding != '0) || (drop_cnt != '0));

    always_comb begin
        outstanding_d = outstanding;
        drop_cnt_d    = drop_cnt;
        state_d       = state;
        if (issue && !rsp_accept) begin
            outstanding_d = outstanding + 1'b1;
        end else if (!issue && rsp_accept) begin
            outstanding_d = outstanding - 1'b1;
        end
        // No issue happens in a redirect cycle, so this is outstanding minus any response now
        if (redirect_i) begin
            drop_cnt_d = outstanding_d;
        end else if (rsp_accept && (drop_cnt != '0)) begin
            drop_cnt_d = drop_cnt - 1'b1;
        end
        state_d = (drop_cnt_d != '0) ? FLUSH : FETCH;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            meta_wr     <= '0;
            meta_rd     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_d;
            outstanding <= outstanding_d;
            drop_cnt    <= drop_cnt_d;
            if (rsp_accept) begin
                meta_rd <= meta_inc(meta_rd);
            end
            if (redirect_i) begin
                pc     <= redirect_pc_i;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (issue) begin
                    pc      <= pc_inc(pc);
                    meta_wr <= meta_inc(meta_wr);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (!push && pop) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and counters
    always_ff @(posedge clk) begin
        if (issue) begin
            meta_pc[meta_wr] <= pc;
        end
        if (push) begin
            fifo_pc[wr_ptr]    <= meta_pc[meta_rd];
            fifo_pc4[wr_ptr]   <= pc_inc(meta_pc[meta_rd]);
            fifo_instr[wr_ptr] <= im_rdata_i;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && !pop && (count == CW'(FETCH_DEPTH))))
                else $error("fetch fifo overflow");
            assert (!(pop && empty))
                else $error("fetch fifo underflow");
            assert (!(!issue && rsp_accept && (outstanding == '0)))
                else $error("outstanding underflow");
            assert (!redirect_i || (redirect_pc_i[1:0] == 2'b00))
                else $error("redirect target not 4-byte aligned");
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a small instruction-memory responder plus
// per-scenario tasks with hand-computed expected PCs, addresses and flags.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst, redirect_i, halt_i, im_gnt_i, im_rvalid_i, id_ready_i;
    logic [31:0] redirect_pc_i, im_rdata_i;
    logic        im_req_o, id_valid_o, busy_o;
    logic [31:0] im_addr_o, id_pc_o, id_pc_add4_o, id_instr_o;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic        mem_auto, rsp_v;
    logic [31:0] rsp_a;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .FETCH_DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
        .im_req_o(im_req_o), .im_addr_o(im_addr_o), .im_gnt_i(im_gnt_i),
        .im_rvalid_i(im_rvalid_i), .im_rdata_i(im_rdata_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_pc_o(id_pc_o), .id_pc_add4_o(id_pc_add4_o), .id_instr_o(id_instr_o),
        .busy_o(busy_o)
    );

    function automatic logic [31:0] ifn(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Start of a cycle: default control inputs; auto mode answers each grant one cycle later
    task automatic pre();
        @(negedge clk);
        rst        = 1'b1;
        redirect_i = 1'b0;
        if (mem_auto) begin
            im_rvalid_i = rsp_v;
            im_rdata_i  = rsp_v ? ifn(rsp_a) : 32'h0;
        end else begin
            im_rvalid_i = 1'b0;
            im_rdata_i  = 32'h0;
        end
    endtask

    task automatic post();
        logic        iss;
        logic [31:0] a;
        #1;
        iss = im_req_o && im_gnt_i;
        a   = im_addr_o;
        @(posedge clk);
        rsp_v = iss;
        rsp_a = a;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            pre();
            rst = 1'b0; halt_i = 1'b0; im_gnt_i = 1'b1; id_ready_i = 1'b1;
            post();
        end
        rsp_v = 1'b0;
    endtask

    task automatic test_reset();
        mem_auto = 1'b1;
        do_reset();
        pre();
        rst = 1'b0;
        #1;
        n_chk++; if (im_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", im_req_o); end
        n_chk++; if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", id_valid_o); end
        n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_chk++; if ({id_pc_o, id_pc_add4_o, id_instr_o} !== 96'h0) begin n_fail++; $display("FAIL reset_id_data: got %h %h %h want zeros", id_pc_o, id_pc_add4_o, id_instr_o); end
        post();
        pre();
        #1;
        n_chk++; if (im_req_o !== 1'b1 || im_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_first_req: got %b/%h want 1/00000000", im_req_o, im_addr_o); end
        post();
    endtask

    task automatic test_stream();
        mem_auto = 1'b1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            pre();
            #1;
            n_chk++; if (im_req_o !== 1'b1 || im_addr_o !== 32'(c * 4)) begin n_fail++; $display("FAIL stream_req c%0d: got %b/%h want 1/%h", c, im_req_o, im_addr_o, 32'(c * 4)); end
            n_chk++; if (busy_o !== (c >= 1)) begin n_fail++; $display("FAIL stream_busy c%0d: got %b want %b", c, busy_o, (c >= 1)); end
            n_chk++; if (id_valid_o !== (c >= 2)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, id_valid_o, (c >= 2)); end
            if (c >= 2) begin
                n_chk++;
                if (id_pc_o !== 32'((c - 2) * 4) || id_pc_add4_o !== 32'((c - 1) * 4) || id_instr_o !== ifn(32'((c - 2) * 4))) begin
                    n_fail++; $display("FAIL stream_head c%0d: got %h/%h/%h want %h/%h/%h", c, id_pc_o, id_pc_add4_o, id_instr_o, 32'((c - 2) * 4), 32'((c - 1) * 4), ifn(32'((c - 2) * 4)));
                end
            end
            post();
        end
    endtask

    task automatic test_backpressure();
        logic        fill_req  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] drain_pc  [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        logic        drain_req [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] drain_adr [5] = '{32'h10, 32'h10, 32'h14, 32'h18, 32'h1C};
        mem_auto = 1'b1;
        do_reset();
        id_ready_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            pre();
            id_ready_i = 1'b0;
            #1;
            n_chk++; if (im_req_o !== fill_req[c]) begin n_fail++; $display("FAIL bp_fill_req c%0d: got %b want %b", c, im_req_o, fill_req[c]); end
            if (c >= 2) begin
                n_chk++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0) begin n_fail++; $display("FAIL bp_hold_head c%0d: got %b/%h want 1/00000000", c, id_valid_o, id_pc_o); end
            end
            post();
        end
        for (int k = 0; k < 5; k++) begin
            pre();
            id_ready_i = 1'b1;
            #1;
            n_chk++; if (id_valid_o !== 1'b1 || id_pc_o !== drain_pc[k]) begin n_fail++; $display("FAIL bp_drain k%0d: got %b/%h want 1/%h", k, id_valid_o, id_pc_o, drain_pc[k]); end
            n_chk++; if (im_req_o !== drain_req[k] || (drain_req[k] && im_addr_o !== drain_adr[k])) begin n_fail++; $display("FAIL bp_resume k%0d: got %b/%h want %b/%h", k, im_req_o, im_addr_o, drain_req[k], drain_adr[k]); end
            post();
        end
    endtask

    // Leaves 0x8 and 0xC outstanding with 0x0 consumed; ready_e decides whether 0x4 stays buffered
    task automatic setup_two_out(input logic ready_e);
        mem_auto = 1'b0;
        do_reset();
        pre(); post();
        pre(); post();
        pre(); im_rvalid_i = 1'b1; im_rdata_i = ifn(32'h0); post();
        pre(); im_rvalid_i = 1'b1; im_rdata_i = ifn(32'h4); post();
        pre(); id_ready_i = ready_e;
        #1;
        n_chk++; if (im_req_o !== 1'b1 || im_addr_o !== 32'hC) begin n_fail++; $display("FAIL setup_req_c: got %b/%h want 1/0000000c", im_req_o, im_addr_o); end
        post();
    endtask

    task automatic test_redirect_flush();
        setup_two_out(1'b1);
        pre(); redirect_i = 1'b1; redirect_pc_i = 32'h100;
        #1;
        n_chk++; if (im_req_o !== 1'b0 || id_valid_o !== 1'b0) begin n_fail++; $display("FAIL rf_redir_cycle: got req %b valid %b want 0 0", im_req_o, id_valid_o); end
        post();
        pre(); im_rvalid_i = 1'b1; im_rdata_i = ifn(32'h8);
        #1;
        n_chk++; if (busy_o !== 1'b1 || im_req_o !== 1'b0 || id_valid_o !== 1'b0) begin n_fail++; $display("FAIL rf_drop1: got busy %b req %b valid %b want 1 0 0", busy_o, im_req_o, id_valid_o); end
        post();
        pre(); im_rvalid_i = 1'b1; im_rdata_i = ifn(32'hC);
        #1;
        n_chk++; if (im_req_o !== 1'b1 || im_addr_o !== 32'h100 || id_valid_o !== 1'b0) begin n_fail++; $display("FAIL rf_target_req: got %b/%h valid %b want 1/00000100 0", im_req_o, im_addr_o, id_valid_o); end
        post();
        pre(); im_rvalid_i = 1'b1; im_rdata_i = ifn(32'h100);
        #1;
        n_chk++; if (id_valid_o !== 1'b0 || im_addr_o !== 32'h104) begin n_fail++; $display("FAIL rf_latency: got valid %b addr %h want 0 00000104", id_valid_o, im_addr_o); end
        post();
        pre(); im_gnt_i = 1'b0; im_rvalid_i = 1'b1; im_rdata_i = ifn(32'h104);
        #1;
        n_chk++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h100 || id_pc_add4_o !== 32'h104 || id_instr_o !== ifn(32'h100)) begin n_fail++; $display("FAIL rf_first_target: got %b %h/%h/%h want 1 00000100/00000104/%h", id_valid_o, id_pc_o, id_pc_add4_o, id_instr_o, ifn(32'h100)); end
        post();
        pre();
        #1;
        n_chk++; if (id_pc_o !== 32'h104 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rf_drained: got pc %h busy %b want 00000104 0", id_pc_o, busy_o); end
        post();
    endtask

    task automatic test_redirect_collide();
        setup_two_out(1'b0);
        pre(); id_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
        im_rvalid_i = 1'b1; im_rdata_i = ifn(32'h8);
        #1;
        n_chk++; if (id_valid_o !== 1'b0 || im_req_o !== 1'b0) begin n_fail++; $display("FAIL rc_redir_cycle: got valid %b req %b want 0 0", id_valid_o, im_req_o); end
        post();
        pre(); im_rvalid_i = 1'b1; im_rdata_i = ifn(32'hC);
        #1;
        n_chk++; if (busy_o !== 1'b1 || id_valid_o !== 1'b0 || im_req_o !== 1'b1 || im_addr_o !== 32'h200) begin n_fail++; $display("FAIL rc_flush_issue: got busy %b valid %b req %b addr %h want 1 0 1 00000200", busy_o, id_valid_o, im_req_o, im_addr_o); end
        post();
        pre(); im_gnt_i = 1'b0; im_rvalid_i = 1'b1; im_rdata_i = ifn(32'h200);
        #1;
        n_chk++; if (id_valid_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL rc_no_stale: got valid %b pc %h busy %b want 0 - 1", id_valid_o, id_pc_o, busy_o); end
        post();
        pre();
        #1;
        n_chk++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h200 || id_pc_add4_o !== 32'h204 || id_instr_o !== ifn(32'h200) || busy_o !== 1'b0) begin n_fail++; $display("FAIL rc_target: got %b %h/%h/%h busy %b want 1 00000200/00000204/%h 0", id_valid_o, id_pc_o, id_pc_add4_o, id_instr_o, busy_o, ifn(32'h200)); end
        post();
    endtask

    task automatic test_halt();
        logic        h_gnt [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        h_hlt [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        h_req [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] h_adr [5] = '{32'hC, 32'hC, 32'hC, 32'hC, 32'h10};
        logic        h_vld [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] h_pc  [5] = '{32'h4, 32'h8, 32'h0, 32'h0, 32'h0};
        mem_auto = 1'b1;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            pre(); post();
        end
        for (int c = 0; c < 5; c++) begin
            pre(); halt_i = h_hlt[c]; im_gnt_i = h_gnt[c];
            #1;
            n_chk++; if (im_req_o !== h_req[c] || im_addr_o !== h_adr[c]) begin n_fail++; $display("FAIL halt_req c%0d: got %b/%h want %b/%h", c, im_req_o, im_addr_o, h_req[c], h_adr[c]); end
            n_chk++; if (id_valid_o !== h_vld[c] || (h_vld[c] && id_pc_o !== h_pc[c])) begin n_fail++; $display("FAIL halt_pop c%0d: got %b/%h want %b/%h", c, id_valid_o, id_pc_o, h_vld[c], h_pc[c]); end
            post();
        end
        pre();
        #1;
        n_chk++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'hC) begin n_fail++; $display("FAIL halt_resume: got %b/%h want 1/0000000c", id_valid_o, id_pc_o); end
        post();
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] w_adr [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        logic [31:0] w_pc  [5] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        logic [31:0] w_p4  [5] = '{32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4};
        mem_auto = 1'b1;
        do_reset();
        pre(); im_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        #1;
        n_chk++; if (im_req_o !== 1'b0) begin n_fail++; $display("FAIL wrap_redir_req: got %b want 0", im_req_o); end
        post();
        im_gnt_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            pre();
            #1;
            n_chk++; if (im_req_o !== 1'b1 || im_addr_o !== w_adr[c]) begin n_fail++; $display("FAIL wrap_addr c%0d: got %b/%h want 1/%h", c, im_req_o, im_addr_o, w_adr[c]); end
            if (c >= 2) begin
                n_chk++; if (id_valid_o !== 1'b1 || id_pc_o !== w_pc[c] || id_pc_add4_o !== w_p4[c]) begin n_fail++; $display("FAIL wrap_head c%0d: got %b %h/%h want 1 %h/%h", c, id_valid_o, id_pc_o, id_pc_add4_o, w_pc[c], w_p4[c]); end
            end
            post();
        end
        pre(); rst = 1'b0;
        #1;
        n_chk++; if (im_req_o !== 1'b0 || id_valid_o !== 1'b0 || busy_o !== 1'b0 || {id_pc_o, id_pc_add4_o, id_instr_o} !== 96'h0) begin n_fail++; $display("FAIL midrst_outputs: got req %b valid %b busy %b data %h/%h/%h want zeros", im_req_o, id_valid_o, busy_o, id_pc_o, id_pc_add4_o, id_instr_o); end
        post();
        pre(); im_rvalid_i = 1'b1; im_rdata_i = 32'hDEAD_BEEF;
        #1;
        n_chk++; if (im_req_o !== 1'b1 || im_addr_o !== 32'h0 || id_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_restart: got req %b addr %h valid %b busy %b want 1 00000000 0 0", im_req_o, im_addr_o, id_valid_o, busy_o); end
        post();
        pre();
        #1;
        n_chk++; if (id_valid_o !== 1'b0 || busy_o !== 1'b1 || im_addr_o !== 32'h4) begin n_fail++; $display("FAIL stray_rsp: got valid %b busy %b addr %h want 0 1 00000004", id_valid_o, busy_o, im_addr_o); end
        post();
        pre();
        #1;
        n_chk++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || id_instr_o !== ifn(32'h0)) begin n_fail++; $display("FAIL midrst_first: got %b %h/%h want 1 00000000/%h", id_valid_o, id_pc_o, id_instr_o, ifn(32'h0)); end
        post();
    endtask

    initial begin
        rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; halt_i = 1'b0;
        im_gnt_i = 1'b0; im_rvalid_i = 1'b0; im_rdata_i = 32'h0; id_ready_i = 1'b0;
        mem_auto = 1'b0; rsp_v = 1'b0; rsp_a = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_collide();
        test_halt();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage for the 5-stage RISC-V core. It keeps the PC, issues pipelined requests to instruction memory over a grant/rvalid handshake, and buffers returned instructions with their PC and PC+4 in a FETCH_DEPTH-entry FIFO. It presents them to ID over valid/ready. Branch/jump redirects from EX flush the FIFO and discard in-flight responses.

Parameters:
XLEN, 32, width of PC, address and instruction data
RESET_PC, 32'h0000_0000, PC loaded on reset
FETCH_DEPTH, 4, fetch FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum accepted but unreturned memory requests (>=1, <=FETCH_DEPTH)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset (sampled on rising edge of clk, low = reset)
redirect_i  in  1  EX branch taken / jump: flush and restart at redirect_pc_i
redirect_pc_i  in  XLEN  redirect target
halt_i  in  1  hazard hold: suppress new memory requests, PC unchanged
im_req_o  out  1  memory request valid
im_addr_o  out  XLEN  request address (current PC)
im_gnt_i  in  1  memory accepts request this cycle (im_req_o && im_gnt_i = issue)
im_rvalid_i  in  1  response valid (in request order)
im_rdata_i  in  XLEN  response instruction
id_valid_o  out  1  FIFO head valid to ID
id_ready_i  in  1  ID accepts head (pop = id_valid_o && id_ready_i)
id_pc_o  out  XLEN  head PC
id_pc_add4_o  out  XLEN  head PC+4
id_instr_o  out  XLEN  head instruction
busy_o  out  1  outstanding requests or drop count nonzero

Behaviour:
- Reset (rst==0 at edge): pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=FETCH. Outputs in reset: im_req_o=0, id_valid_o=0, busy_o=0, id_* = 0.
- Credit rule: im_req_o = !rst_active && !redirect_i && !halt_i && outstanding<MAX_OUTSTANDING && (fifo_count+outstanding-drop_cnt)<FETCH_DEPTH. Accepted responses can never overflow the FIFO.
- im_addr_o = pc. On issue, pc <= pc+4 (mod 2^XLEN, wraps at 0xFFFF_FFFC -> 0). Request metadata FIFO (MAX_OUTSTANDING deep) stores the issued PC.
- outstanding: +1 on issue, -1 on im_rvalid_i, unchanged if both occur in the same cycle.
- Response: if drop_cnt==0, push {pc_meta, pc_meta+4, im_rdata_i} into FIFO. Otherwise discard and drop_cnt-1. The metadata entry is popped in both cases.
- FIFO: circular, registered storage. id_* come from the head entry. id_valid_o = !empty && !redirect_i. Push and pop in the same cycle are both performed, count unchanged. Push when empty is visible to ID the next cycle (1-cycle rvalid->id_valid latency).
- Redirect (priority over halt, issue and pop): at the edge, pc<=redirect_pc_i, FIFO cleared, drop_cnt <= outstanding minus (1 if im_rvalid_i this cycle). A response arriving in the redirect cycle is discarded. No request is issued in the redirect cycle. First request to target is issued the next cycle, subject to credit.
- Redirect while drop_cnt>0: drop_cnt recomputed as above (equals new outstanding). The FSM stays or returns to FLUSH.
- FSM: FETCH (drop_cnt==0) and FLUSH (drop_cnt>0).
  - FETCH->FLUSH: redirect with nonzero effective outstanding.
  - FLUSH->FETCH: when drop_cnt reaches 0.
  - Issuing is allowed in FLUSH. Ordering guarantees the new responses follow the dropped ones.
- halt_i: no issue, pc held. Responses still accepted and ID pops still allowed.
- busy_o = (outstanding!=0) || (drop_cnt!=0).
- Reset mid-operation clears everything regardless of pending handshakes. Responses arriving after reset with outstanding==0 are ignored (no push, no underflow).
- Assertions: no FIFO overflow/underflow, no outstanding underflow, redirect_pc_i 4-byte aligned.

Test Plan:
- Reset release, im_gnt_i=1 always, rvalid 1 cycle after grant, id_ready_i=1 -> requests at 0x0,0x4,0x8,...; ID sees id_pc_o 0x0 then 0x4 with id_pc_add4_o 0x4/0x8 and matching instr; steady-state 1 instr/cycle.
- id_ready_i=0 with FETCH_DEPTH=4 -> exactly 4 instructions buffered, im_req_o drops to 0, no overflow; raising ready drains 0x0..0xC in order, then fetch resumes at 0x10.
- 2 requests outstanding (0x8,0xC), redirect_i=1 with redirect_pc_i=0x100 -> FIFO empty, drop_cnt=2, both responses discarded, next ID instruction has id_pc_o=0x100, busy_o low after drain.
- Redirect in same cycle as a response and as an ID pop -> response discarded, pop ignored, drop_cnt = outstanding-1, no ID output at stale PC.
- halt_i=1 for 3 cycles mid-stream, im_gnt_i toggling -> no issue during halt, pc held, buffered entries still popped, fetch resumes at held PC.
- pc=0xFFFF_FFF8 via redirect -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; id_pc_add4_o of 0xFFFF_FFFC entry is 0x0; rst=0 mid-stream -> all outputs zero next cycle, restart at RESET_PC.
